fetch_stage: RTL and testbench
==============================

# fetch_stage

Instruction-fetch stage of the LC3 pipeline, directly upstream of decode. Holds the PC and issues reads to instruction memory through a ready handshake that may insert wait states. It captures the returned word and hands decode a registered `instr_dout`, the matching `npc_in` value (`npc_out` here), and a one-cycle `enable_decode` strobe. It also applies taken-branch redirects from execute/writeback and flags a memory timeout.

## Interface
- `RESET_PC`, 16'h3000: PC value loaded on reset.
- `MAX_WAIT`, 8: number of consecutive not-ready cycles that triggers a timeout (range 1–255).
- `clk` in 1: clock; all logic is on the rising edge.
- `rst` in 1: reset; synchronous, active-high.
- `enable_fetch` in 1: permits issuing memory reads.
- `enable_updatePC` in 1: permits PC advance or redirect.
- `br_taken` in 1: taken branch/jump; redirects the PC to `taddr`.
- `taddr` in 16: branch target.
- `imem_ready` in 1: memory returns valid `imem_rdata` this cycle.
- `imem_rdata` in 16: instruction word from memory.
- `pc` out 16: current fetch address, driven to memory.
- `instrmem_rd` out 1: read request.
- `instr_dout` out 16: registered instruction to decode.
- `npc_out` out 16: PC+1 of the instruction in `instr_dout`; drives decode `npc_in`.
- `enable_decode` out 1: one-cycle strobe meaning `instr_dout`/`npc_out` are new.
- `fetch_err` out 1: sticky timeout flag.
- `stall_cnt` out 16: present only with `FETCH_STALL_CNT_EN`.

## Operation
- **States:** IDLE, REQ, ERR.
  - `instrmem_rd` = (state==REQ), decoded combinationally from the state register.
- **IDLE:** if `enable_fetch`, go to REQ on the next edge; otherwise stay.
- **REQ:**
  - If `enable_fetch`=0, go to IDLE. Any response in that cycle is ignored and the PC is held.
  - **Capture** occurs when state==REQ, `enable_fetch`=1, and `imem_ready`=1, and no redirect is active in that cycle. On capture:
    - `instr_dout` <= `imem_rdata`
    - `npc_out` <= `pc`+1
    - `enable_decode` <= 1
    - wait counter <= 0
    - if `enable_updatePC`, `pc` <= `pc`+1; otherwise `pc` holds and the same address is re-fetched.
  - **Redirect** occurs when `br_taken` && `enable_updatePC`, in any state other than ERR:
    - `pc` <= `taddr`
    - wait counter <= 0
    - a coincident response is discarded, so `enable_decode` <= 0
    - the state is unchanged.
  - **Wait:** when `imem_ready`=0 in REQ, the wait counter increments.
  - **Timeout:** when the counter reaches `MAX_WAIT`-1 and `imem_ready` is still 0, go to ERR and set `fetch_err` <= 1.
- **ERR:**
  - `instrmem_rd`=0.
  - All inputs are ignored.
  - Only `rst` exits ERR.
- **Strobe rules:**
  - `enable_decode` is 0 in every cycle not immediately following a capture.
  - `instr_dout` and `npc_out` hold their values between captures.
- **Arithmetic:** `pc`+1 is a 16-bit wrap, so 16'hFFFF becomes 16'h0000 with no flag.
- **Wait counter:** 8 bits wide, internal only.

## Timing
- **Reset values:**
  - `pc`=`RESET_PC`
  - `npc_out`=0
  - `instr_dout`=0
  - `enable_decode`=0
  - `instrmem_rd`=0
  - `fetch_err`=0
  - `stall_cnt`=0
  - state=IDLE
  - wait counter=0
- **Start-up:** with `enable_fetch`=1, the first edge after `rst` drops enters REQ, so `instrmem_rd` rises one cycle after reset release.
- **Latency:** `imem_ready` high at edge N gives `enable_decode`=1 and valid data during cycle N+1. Zero wait states give one instruction per cycle.
- **`rst` mid-operation:** all state returns to reset values on that edge, any in-flight response is dropped, and ERR is cleared.
- **Priority (highest first):** `rst` > ERR > redirect > `enable_fetch`=0 > capture > wait.

## Configuration
- **`FETCH_STALL_CNT_EN` defined:**
  - The `stall_cnt` port exists.
  - It increments each cycle with state==REQ, `enable_fetch`=1, and `imem_ready`=0.
  - It saturates at 16'hFFFF and clears only on `rst`.
- **Not defined:** the port and its counter are absent; all other behaviour is identical.

## Test plan
- **Streaming:** `rst`, then `enable_fetch`=`enable_updatePC`=1, `imem_ready`=1, `imem_rdata`=address. `pc` steps 3000, 3001, 3002. `enable_decode` stays high from the third cycle after reset release. The first delivery is `instr_dout`=3000 with `npc_out`=3001.
- **Wait states:** `imem_ready` low for 2 cycles, then high at `pc`=3004. Result is a single `enable_decode` pulse with `instr_dout`=3004 and `npc_out`=3005; `stall_cnt` increases by 2.
- **Branch:** `br_taken`=1 with `taddr`=16'h3050 in the same cycle as `imem_ready`=1. No `enable_decode` pulse follows, and the next `pc`=3050. The next capture delivers `npc_out`=3051.
- **Hold PC:** `enable_updatePC`=0 for 3 cycles at `pc`=3010. Three pulses each deliver 3010 with `npc_out`=3011, and `pc` stays at 3010. Also drop `enable_fetch` during a wait: state goes to IDLE with `instrmem_rd`=0 the next cycle and `pc` unchanged.
- **Timeout:** `MAX_WAIT`=8 with `imem_ready` held low. After 8 REQ cycles, `fetch_err`=1 and `instrmem_rd`=0. `imem_ready` high and `br_taken` then have no effect, and `rst` clears everything to reset values.
- **Wrap:** `taddr`=16'hFFFF, then one capture. `npc_out`=16'h0000 and `pc`=16'h0000.

Source files
------------

// File: rtl/fetch_stage_if.sv
// Instruction-memory port of the fetch stage: address/read request out, ready/data back.
// Purely combinational bundle; no latency of its own. Wait states are signalled by holding imem_ready low.
interface fetch_stage_if;
    logic [15:0] pc;
    logic        instrmem_rd;
    logic        imem_ready;
    logic [15:0] imem_rdata;

    modport master (
        output pc,
        output instrmem_rd,
        input  imem_ready,
        input  imem_rdata
    );

    modport slave (
        input  pc,
        input  instrmem_rd,
        output imem_ready,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_stage.sv
// LC3 fetch stage: PC, imem read handshake, registered handoff to decode; FETCH_STALL_CNT_EN adds stall_cnt.
// Latency: imem_ready at edge N -> enable_decode/instr_dout/npc_out valid in cycle N+1; one instr/cycle streaming.
// Backpressure: memory stalls via imem_ready=0 (timeout -> sticky ERR); enable_fetch/enable_updatePC throttle issue.
module fetch_stage #(
    parameter logic [15:0] RESET_PC = 16'h3000,
    parameter int          MAX_WAIT = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable_fetch,
    input  logic          enable_updatePC,
    input  logic          br_taken,
    input  logic [15:0]   taddr,
    fetch_stage_if.master imem,
    output logic [15:0]   instr_dout,
    output logic [15:0]   npc_out,
    output logic          enable_decode,
`ifdef FETCH_STALL_CNT_EN
    output logic          fetch_err,
    output logic [15:0]   stall_cnt
`else
    output logic          fetch_err
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        ERR  = 2'd2
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(MAX_WAIT - 1);

    state_t      state;
    state_t      state_nxt;
    logic [15:0] pc_q;
    logic [15:0] pc_inc;
    logic [7:0]  wait_cnt;
    logic        redirect;
    logic        capture;
    logic        wait_inc;
    logic        timeout;

    assign pc_inc           = pc_q + 16'd1;
    assign imem.pc          = pc_q;
    assign imem.instrmem_rd = (state == REQ);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Redirect outranks everything but ERR and keeps the state; a coincident response is dropped.
    always_comb begin
        state_nxt = state;
        redirect  = 1'b0;
        capture   = 1'b0;
        wait_inc  = 1'b0;
        timeout   = 1'b0;
        case (state)
            IDLE: begin
                if (br_taken && enable_updatePC) begin
                    redirect = 1'b1;
                end else if (enable_fetch) begin
                    state_nxt = REQ;
                end
            end
            REQ: begin
                if (br_taken && enable_updatePC) begin
                    redirect = 1'b1;
                end else if (!enable_fetch) begin
                    state_nxt = IDLE;
                end else if (imem.imem_ready) begin
                    capture = 1'b1;
                end else if (wait_cnt == WAIT_LAST) begin
                    timeout   = 1'b1;
                    state_nxt = ERR;
                end else begin
                    wait_inc = 1'b1;
                end
            end
            ERR: begin
                state_nxt = ERR;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            wait_cnt      <= 8'd0;
            instr_dout    <= 16'd0;
            npc_out       <= 16'd0;
            enable_decode <= 1'b0;
            fetch_err     <= 1'b0;
        end else begin
            enable_decode <= capture;
            if (redirect) begin
                pc_q     <= taddr;
                wait_cnt <= 8'd0;
            end
            if (capture) begin
                instr_dout <= imem.imem_rdata;
                npc_out    <= pc_inc;
                wait_cnt   <= 8'd0;
                if (enable_updatePC) begin
                    pc_q <= pc_inc;
                end
            end
            if (wait_inc) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (timeout) begin
                fetch_err <= 1'b1;
            end
        end
    end

`ifdef FETCH_STALL_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= 16'd0;
        end else if (state == REQ && enable_fetch && !imem.imem_ready && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: memory returns its own address as the instruction word.
module tb_fetch_stage;

    logic        clk;
    logic        rst;
    logic        enable_fetch;
    logic        enable_updatePC;
    logic        br_taken;
    logic [15:0] taddr;
    logic [15:0] instr_dout;
    logic [15:0] npc_out;
    logic        enable_decode;
    logic        fetch_err;
`ifdef FETCH_STALL_CNT_EN
    logic [15:0] stall_cnt;
    logic [15:0] stall_base;
`endif

    int n_cmp;
    int n_err;

    fetch_stage_if bus ();

    assign bus.imem_rdata = bus.pc;

    fetch_stage #(
        .RESET_PC (16'h3000),
        .MAX_WAIT (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .enable_fetch    (enable_fetch),
        .enable_updatePC (enable_updatePC),
        .br_taken        (br_taken),
        .taddr           (taddr),
        .imem            (bus.master),
        .instr_dout      (instr_dout),
        .npc_out         (npc_out),
        .enable_decode   (enable_decode),
`ifdef FETCH_STALL_CNT_EN
        .fetch_err       (fetch_err),
        .stall_cnt       (stall_cnt)
`else
        .fetch_err       (fetch_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check_eq({tag, "_pc"},    bus.pc,                 16'h3000);
        check_eq({tag, "_rd"},    {15'd0, bus.instrmem_rd}, 16'd0);
        check_eq({tag, "_instr"}, instr_dout,             16'h0000);
        check_eq({tag, "_npc"},   npc_out,                16'h0000);
        check_eq({tag, "_dec"},   {15'd0, enable_decode}, 16'd0);
        check_eq({tag, "_err"},   {15'd0, fetch_err},     16'd0);
`ifdef FETCH_STALL_CNT_EN
        check_eq({tag, "_stall"}, stall_cnt,              16'd0);
`endif
    endtask

    initial begin
        n_cmp           = 0;
        n_err           = 0;
        rst             = 1'b1;
        enable_fetch    = 1'b0;
        enable_updatePC = 1'b0;
        br_taken        = 1'b0;
        taddr           = 16'h0000;
        bus.imem_ready  = 1'b0;
        tick();
        tick();
        check_reset_state("reset");

        // Streaming, zero wait states
        rst             = 1'b0;
        enable_fetch    = 1'b1;
        enable_updatePC = 1'b1;
        bus.imem_ready  = 1'b1;
        tick();
        check_eq("start_rd",  {15'd0, bus.instrmem_rd}, 16'd1);
        check_eq("start_pc",  bus.pc,                   16'h3000);
        check_eq("start_dec", {15'd0, enable_decode},   16'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("strm_dec",   {15'd0, enable_decode}, 16'd1);
            check_eq("strm_instr", instr_dout,             16'h3000 + 16'(i));
            check_eq("strm_npc",   npc_out,                16'h3001 + 16'(i));
            check_eq("strm_pc",    bus.pc,                 16'h3001 + 16'(i));
        end

        // Two wait states at pc=3004
`ifdef FETCH_STALL_CNT_EN
        stall_base = stall_cnt;
`endif
        bus.imem_ready = 1'b0;
        tick();
        tick();
        check_eq("wait_dec", {15'd0, enable_decode}, 16'd0);
        check_eq("wait_pc",  bus.pc,                 16'h3004);
        bus.imem_ready = 1'b1;
        tick();
        check_eq("wait_dec1",  {15'd0, enable_decode}, 16'd1);
        check_eq("wait_instr", instr_dout,             16'h3004);
        check_eq("wait_npc",   npc_out,                16'h3005);
`ifdef FETCH_STALL_CNT_EN
        check_eq("wait_stall", stall_cnt - stall_base, 16'd2);
`endif
        bus.imem_ready = 1'b0;
        tick();
        check_eq("wait_single", {15'd0, enable_decode}, 16'd0);

        // Branch coincident with a response
        bus.imem_ready = 1'b1;
        br_taken       = 1'b1;
        taddr          = 16'h3050;
        tick();
        check_eq("br_dec",   {15'd0, enable_decode}, 16'd0);
        check_eq("br_pc",    bus.pc,                 16'h3050);
        check_eq("br_instr", instr_dout,             16'h3004);
        br_taken = 1'b0;
        tick();
        check_eq("br_cap_instr", instr_dout, 16'h3050);
        check_eq("br_cap_npc",   npc_out,    16'h3051);

        // Hold PC at 3010
        br_taken = 1'b1;
        taddr    = 16'h3010;
        tick();
        br_taken        = 1'b0;
        enable_updatePC = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq("hold_dec",   {15'd0, enable_decode}, 16'd1);
            check_eq("hold_instr", instr_dout,             16'h3010);
            check_eq("hold_npc",   npc_out,                16'h3011);
            check_eq("hold_pc",    bus.pc,                 16'h3010);
        end

        // Drop enable_fetch during a wait
        enable_updatePC = 1'b1;
        bus.imem_ready  = 1'b0;
        tick();
        enable_fetch = 1'b0;
        tick();
        check_eq("drop_rd", {15'd0, bus.instrmem_rd}, 16'd0);
        check_eq("drop_pc", bus.pc,                   16'h3010);

        // Re-enter REQ and capture once so the wait counter starts from zero
        enable_fetch   = 1'b1;
        bus.imem_ready = 1'b1;
        tick();
        tick();
        check_eq("pre_to_pc", bus.pc, 16'h3011);

        // Timeout after 8 not-ready REQ cycles
        bus.imem_ready = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        check_eq("to_err7", {15'd0, fetch_err},       16'd0);
        check_eq("to_rd7",  {15'd0, bus.instrmem_rd}, 16'd1);
        tick();
        check_eq("to_err8", {15'd0, fetch_err},       16'd1);
        check_eq("to_rd8",  {15'd0, bus.instrmem_rd}, 16'd0);
        bus.imem_ready = 1'b1;
        br_taken       = 1'b1;
        taddr          = 16'h1234;
        tick();
        tick();
        check_eq("err_pc",    bus.pc,                 16'h3011);
        check_eq("err_dec",   {15'd0, enable_decode}, 16'd0);
        check_eq("err_stick", {15'd0, fetch_err},     16'd1);
        check_eq("err_rd",    {15'd0, bus.instrmem_rd}, 16'd0);
        check_eq("err_instr", instr_dout,             16'h3010);
        br_taken = 1'b0;
        rst      = 1'b1;
        tick();
        check_reset_state("rst_err");

        // PC wrap: redirect to FFFF from IDLE, then one capture
        rst            = 1'b0;
        bus.imem_ready = 1'b0;
        br_taken       = 1'b1;
        taddr          = 16'hFFFF;
        tick();
        check_eq("wrap_redir_pc", bus.pc,                   16'hFFFF);
        check_eq("wrap_idle_rd",  {15'd0, bus.instrmem_rd}, 16'd0);
        br_taken = 1'b0;
        tick();
        bus.imem_ready = 1'b1;
        tick();
        check_eq("wrap_instr", instr_dout, 16'hFFFF);
        check_eq("wrap_npc",   npc_out,    16'h0000);
        check_eq("wrap_pc",    bus.pc,     16'h0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
